// File: rtl/scan_mux.sv
// Registered N-channel, W-bit channel selector with fixed-select and auto-scan modes.
// Scan mode dwells DWELL cycles per channel; an optional invert stage acts on the data only.
module scan_mux #(
   parameter int N_CH  = 4,
   parameter int W     = 8,
   parameter int DWELL = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*W-1:0]       d,
   input  logic [$clog2(N_CH)-1:0] sel,
   input  logic                    sel_vld,
   input  logic [1:0]              mode,
   output logic [W-1:0]            out,
   output logic [$clog2(N_CH)-1:0] out_ch,
   output logic                    out_vld,
   output logic                    scan_wrap
);
   localparam int CW  = $clog2(N_CH);
   localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]  LAST_CH   = CW'(N_CH - 1);
   localparam logic [DCW-1:0] LAST_DCNT = DCW'(DWELL - 1);
   localparam logic [CW:0]    NUM_CH    = (CW + 1)'(N_CH);

   logic [W-1:0]   chan [N_CH];
   logic [CW-1:0]  ch_reg, ch_next, eff_ch;
   logic [DCW-1:0] dcnt_reg, dcnt_next, dcnt_cur;
   logic           prev_scan_reg;
   logic           wrap_next;
   logic           sel_ok;
   logic [W-1:0]   out_reg;
   logic [CW-1:0]  out_ch_reg;
   logic           out_vld_reg, scan_wrap_reg;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign chan[gi] = d[gi*W +: W];
   end

   always_comb begin
      sel_ok    = ({1'b0, sel} < NUM_CH);
      // a fresh scan always starts its dwell from zero on the current channel
      dcnt_cur  = prev_scan_reg ? dcnt_reg : '0;
      eff_ch    = ch_reg;
      ch_next   = ch_reg;
      dcnt_next = '0;
      wrap_next = 1'b0;
      if (!mode[0]) begin
         if (sel_vld && sel_ok) begin
            eff_ch = sel;
         end
         ch_next = eff_ch;
      end else begin
         if (dcnt_cur == LAST_DCNT) begin
            dcnt_next = '0;
            ch_next   = (ch_reg == LAST_CH) ? '0 : ch_reg + CW'(1);
         end else begin
            dcnt_next = dcnt_cur + DCW'(1);
         end
         wrap_next = (ch_reg == LAST_CH) && (dcnt_cur == LAST_DCNT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_reg        <= '0;
         dcnt_reg      <= '0;
         prev_scan_reg <= 1'b0;
         out_reg       <= '0;
         out_ch_reg    <= '0;
         out_vld_reg   <= 1'b0;
         scan_wrap_reg <= 1'b0;
      end else begin
         ch_reg        <= ch_next;
         dcnt_reg      <= dcnt_next;
         prev_scan_reg <= mode[0];
         out_reg       <= chan[eff_ch] ^ {W{mode[1]}};
         out_ch_reg    <= eff_ch;
         out_vld_reg   <= 1'b1;
         scan_wrap_reg <= wrap_next;
      end
   end

   assign out       = out_reg;
   assign out_ch    = out_ch_reg;
   assign out_vld   = out_vld_reg;
   assign scan_wrap = scan_wrap_reg;
endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: two builds (4ch/dwell 2 and 3ch/dwell 3) driven in lockstep,
// expected results from a position-based reference model queued per cycle and checked by a monitor.
module tb_scan_mux;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] d_a = '0;
   logic [23:0] d_b = '0;
   logic [1:0]  sel = '0;
   logic        sel_vld = 1'b0;
   logic [1:0]  mode = '0;

   logic [7:0] out_a, out_b;
   logic [1:0] out_ch_a, out_ch_b;
   logic       out_vld_a, out_vld_b, scan_wrap_a, scan_wrap_b;

   always #5 clk = ~clk;

   scan_mux #(.N_CH(4), .W(8), .DWELL(2)) dut_a (
      .clk(clk), .rst(rst), .d(d_a), .sel(sel), .sel_vld(sel_vld), .mode(mode),
      .out(out_a), .out_ch(out_ch_a), .out_vld(out_vld_a), .scan_wrap(scan_wrap_a)
   );

   scan_mux #(.N_CH(3), .W(8), .DWELL(3)) dut_b (
      .clk(clk), .rst(rst), .d(d_b), .sel(sel), .sel_vld(sel_vld), .mode(mode),
      .out(out_b), .out_ch(out_ch_b), .out_vld(out_vld_b), .scan_wrap(scan_wrap_b)
   );

   typedef struct {
      logic [7:0] o_a;  logic [1:0] c_a;  logic v_a;  logic w_a;
      logic [7:0] o_b;  logic [1:0] c_b;  logic v_b;  logic w_b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   txn = 0;

   logic [7:0] dch [4];

   // Reference state: a scan position pos in 0..n*dwell-1 (channel = pos/dwell).
   int n_ch  [2] = '{4, 3};
   int dwell [2] = '{2, 3};
   int m_ch  [2] = '{0, 0};
   int m_pos [2] = '{0, 0};
   bit m_prev[2] = '{0, 0};

   task automatic model_step(input int u, output logic [7:0] eo, output logic [1:0] ec,
                             output logic ev, output logic ew);
      int c;
      int period;
      period = n_ch[u] * dwell[u];
      if (rst) begin
         eo = 8'h00; ec = 2'd0; ev = 1'b0; ew = 1'b0;
         m_ch[u] = 0; m_pos[u] = 0; m_prev[u] = 0;
      end else begin
         if (!mode[0]) begin
            c = (sel_vld && int'(sel) < n_ch[u]) ? int'(sel) : m_ch[u];
            m_ch[u] = c;
            ew = 1'b0;
         end else begin
            if (!m_prev[u]) m_pos[u] = m_ch[u] * dwell[u];
            c  = m_pos[u] / dwell[u];
            ew = (m_pos[u] == period - 1);
            m_pos[u] = (m_pos[u] + 1) % period;
            m_ch[u]  = m_pos[u] / dwell[u];
         end
         m_prev[u] = mode[0];
         eo = dch[c] ^ {8{mode[1]}};
         ec = 2'(c);
         ev = 1'b1;
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] s, input logic sv, input logic [1:0] m);
      exp_t e;
      @(negedge clk);
      rst = r; sel = s; sel_vld = sv; mode = m;
      d_a = {dch[3], dch[2], dch[1], dch[0]};
      d_b = {dch[2], dch[1], dch[0]};
      model_step(0, e.o_a, e.c_a, e.v_a, e.w_a);
      model_step(1, e.o_b, e.c_b, e.v_b, e.w_b);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d a: out=%02h ch=%0d vld=%0b wrap=%0b | b: out=%02h ch=%0d vld=%0b wrap=%0b",
                  txn, out_a, out_ch_a, out_vld_a, scan_wrap_a, out_b, out_ch_b, out_vld_b, scan_wrap_b);
         chk("a_out",  out_a,             e.o_a);
         chk("a_ch",   {6'd0, out_ch_a},  {6'd0, e.c_a});
         chk("a_vld",  {7'd0, out_vld_a}, {7'd0, e.v_a});
         chk("a_wrap", {7'd0, scan_wrap_a}, {7'd0, e.w_a});
         chk("b_out",  out_b,             e.o_b);
         chk("b_ch",   {6'd0, out_ch_b},  {6'd0, e.c_b});
         chk("b_vld",  {7'd0, out_vld_b}, {7'd0, e.v_b});
         chk("b_wrap", {7'd0, scan_wrap_b}, {7'd0, e.w_b});
      end
   end

   initial begin
      dch = '{8'h11, 8'h22, 8'h33, 8'h44};
      // reset with arbitrary inputs
      drive(1, 2'd3, 1, 2'b11);
      drive(1, 2'd1, 1, 2'b01);
      // fixed select, hold, out-of-range sel on the 3-channel build, invert
      drive(0, 2'd0, 0, 2'b00);
      drive(0, 2'd2, 1, 2'b00);
      drive(0, 2'd1, 0, 2'b00);
      drive(0, 2'd3, 1, 2'b00);
      drive(0, 2'd2, 1, 2'b00);
      drive(0, 2'd0, 0, 2'b10);
      drive(0, 2'd0, 0, 2'b00);
      // scan from channel 0, plain then inverted
      drive(1, 2'd0, 0, 2'b00);
      for (int i = 0; i < 13; i++) drive(0, 2'd2, 1, 2'b01);
      drive(1, 2'd0, 0, 2'b00);
      for (int i = 0; i < 13; i++) drive(0, 2'd0, 0, 2'b11);
      // fixed on ch1 then scan starts from ch1
      drive(0, 2'd1, 1, 2'b00);
      for (int i = 0; i < 7; i++) drive(0, 2'd0, 0, 2'b01);
      // leave scan mid-dwell
      drive(0, 2'd0, 0, 2'b00);
      drive(0, 2'd0, 0, 2'b00);
      // reset mid-scan, then resume scanning
      for (int i = 0; i < 5; i++) drive(0, 2'd0, 0, 2'b01);
      drive(1, 2'd0, 0, 2'b01);
      for (int i = 0; i < 8; i++) drive(0, 2'd0, 0, 2'b01);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [1:0] m;
         m = mode;
         if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < 4; k++) dch[k] = 8'($urandom);
         end
         drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), m);
      end
      drive(0, 2'd0, 0, 2'b00);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
